// File: rtl/ras_ckpt_pkg.sv
// Shared return-address-stack types: pointer, occupancy and the checkpoint
// bundle that fetch and the ROB carry with each prediction.
package ras_ckpt_pkg;

   localparam int RAS_ENTRIES_DEF     = 16;
   localparam int LOG_RAS_ENTRIES_DEF = $clog2(RAS_ENTRIES_DEF);
   localparam int ENTRY_WIDTH_DEF     = 38;

   typedef logic [LOG_RAS_ENTRIES_DEF-1:0] RAS_ptr_t;
   typedef logic [LOG_RAS_ENTRIES_DEF:0]   RAS_count_t;

   typedef struct packed {
      RAS_ptr_t   ptr;
      RAS_count_t count;
   } RAS_ckpt_t;

endpackage

// File: rtl/ras_ckpt.sv
// Circular return address stack with occupancy count and checkpoint restore.
// Optional top-entry repair on restore: define RAS_CKPT_TOP_REPAIR_EN.
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int RAS_ENTRIES     = RAS_ENTRIES_DEF,
   parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES),
   parameter int ENTRY_WIDTH     = ENTRY_WIDTH_DEF
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push_valid,
   input  logic [ENTRY_WIDTH-1:0]     push_pc38,
   input  logic                       pop_valid,
   output logic [ENTRY_WIDTH-1:0]     top_pc38,
   output logic                       top_valid,
   output logic [LOG_RAS_ENTRIES-1:0] ckpt_ptr,
   output logic [LOG_RAS_ENTRIES:0]   ckpt_count,
   input  logic                       restore_valid,
   input  logic [LOG_RAS_ENTRIES-1:0] restore_ptr,
   input  logic [LOG_RAS_ENTRIES:0]   restore_count
`ifdef RAS_CKPT_TOP_REPAIR_EN
   ,
   input  logic                       restore_top_valid,
   input  logic [ENTRY_WIDTH-1:0]     restore_top_pc38
`endif
);

   typedef logic [LOG_RAS_ENTRIES-1:0] ptr_t;
   typedef logic [LOG_RAS_ENTRIES:0]   count_t;
   typedef logic [ENTRY_WIDTH-1:0]     entry_t;

   localparam count_t CNT_MAX = count_t'(RAS_ENTRIES);

   entry_t stack_q [RAS_ENTRIES];
   ptr_t   ptr_q, ptr_d, ptr_inc;
   count_t cnt_q, cnt_d;
   logic   wr_en;
   ptr_t   wr_idx;
   entry_t wr_data;

   assign ptr_inc = ptr_q + ptr_t'(1);

   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      wr_data = push_pc38;
      if (restore_valid) begin
         ptr_d = restore_ptr;
         cnt_d = (restore_count > CNT_MAX) ? CNT_MAX : restore_count;
`ifdef RAS_CKPT_TOP_REPAIR_EN
         wr_en   = restore_top_valid;
         wr_idx  = restore_ptr;
         wr_data = restore_top_pc38;
`endif
      end else if (push_valid && pop_valid) begin
         // Replace the top in place: return then call again.
         wr_en = 1'b1;
         cnt_d = (cnt_q == '0) ? count_t'(1) : cnt_q;
      end else if (push_valid) begin
         ptr_d  = ptr_inc;
         wr_en  = 1'b1;
         wr_idx = ptr_inc;
         cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + count_t'(1);
      end else if (pop_valid) begin
         // Pointer moves even when empty so checkpoints stay aligned.
         ptr_d = ptr_q - ptr_t'(1);
         cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - count_t'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < RAS_ENTRIES; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (wr_en) begin
            stack_q[wr_idx] <= wr_data;
         end
      end
   end

   assign top_pc38   = stack_q[ptr_q];
   assign top_valid  = (cnt_q != '0);
   assign ckpt_ptr   = ptr_q;
   assign ckpt_count = cnt_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: expected outputs are queued as stimulus
// is driven and compared one cycle later.
module tb_ras_ckpt;

   logic        CLK;
   logic        RST;
   logic        push_valid;
   logic [37:0] push_pc38;
   logic        pop_valid;
   logic [37:0] top_pc38;
   logic        top_valid;
   logic [3:0]  ckpt_ptr;
   logic [4:0]  ckpt_count;
   logic        restore_valid;
   logic [3:0]  restore_ptr;
   logic [4:0]  restore_count;
`ifdef RAS_CKPT_TOP_REPAIR_EN
   logic        restore_top_valid;
   logic [37:0] restore_top_pc38;
`endif

   typedef struct {
      string       tag;
      logic [37:0] top;
      logic        tv;
      logic [3:0]  ptr;
      logic [4:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   ras_ckpt dut (
      .CLK           (CLK),
      .RST           (RST),
      .push_valid    (push_valid),
      .push_pc38     (push_pc38),
      .pop_valid     (pop_valid),
      .top_pc38      (top_pc38),
      .top_valid     (top_valid),
      .ckpt_ptr      (ckpt_ptr),
      .ckpt_count    (ckpt_count),
      .restore_valid (restore_valid),
      .restore_ptr   (restore_ptr),
      .restore_count (restore_count)
`ifdef RAS_CKPT_TOP_REPAIR_EN
      ,
      .restore_top_valid (restore_top_valid),
      .restore_top_pc38  (restore_top_pc38)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      push_valid    = 1'b0;
      pop_valid     = 1'b0;
      restore_valid = 1'b0;
      RST           = 1'b0;
`ifdef RAS_CKPT_TOP_REPAIR_EN
      restore_top_valid = 1'b0;
`endif
   endtask

   task automatic drive(input logic pu, input logic po, input logic [37:0] d);
      push_valid = pu;
      pop_valid  = po;
      push_pc38  = d;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
   endtask

   task automatic expect_q(input string t, input logic [37:0] top,
                           input logic tv, input logic [3:0] p,
                           input logic [4:0] c);
      exp_t e;
      e.tag = t; e.top = top; e.tv = tv; e.ptr = p; e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      RST = 1'b1;
      drive(1'b1, 1'b0, 38'h3ff);
      restore_valid = 1'b1;
      restore_ptr   = 4'd7;
      restore_count = 5'd9;
      expect_q("reset_prio", 38'h0, 1'b0, 4'd0, 5'd0);
      tick();
      expect_q("reset_idle", 38'h0, 1'b0, 4'd0, 5'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         total++;
         if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
             {e.top, e.tv, e.ptr, e.cnt}) begin
            bad++;
            $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                     e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                     e.top, e.tv, e.ptr, e.cnt);
         end
      end
   endtask

   task automatic test_push_pop();
      exp_t e;
      logic [37:0] d [3];
      logic        po [3];
      d[0] = 38'h100; d[1] = 38'h200; d[2] = 38'h0;
      po[0] = 1'b0; po[1] = 1'b0; po[2] = 1'b1;
      do_reset();
      expect_q("pp_push100", 38'h100, 1'b1, 4'd1, 5'd1);
      expect_q("pp_push200", 38'h200, 1'b1, 4'd2, 5'd2);
      expect_q("pp_pop",     38'h100, 1'b1, 4'd1, 5'd1);
      for (int i = 0; i < 3; i++) begin
         drive(!po[i], po[i], d[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
             {e.top, e.tv, e.ptr, e.cnt}) begin
            bad++;
            $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                     e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                     e.top, e.tv, e.ptr, e.cnt);
         end
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, 1'b0, 38'(k));
         expect_q($sformatf("ovf_push%0d", k), 38'(k), 1'b1, 4'(k % 16),
                  5'((k > 16) ? 16 : k));
         tick();
         e = exp_q.pop_front();
         total++;
         if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
             {e.top, e.tv, e.ptr, e.cnt}) begin
            bad++;
            $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                     e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                     e.top, e.tv, e.ptr, e.cnt);
         end
      end
      for (int j = 1; j <= 17; j++) begin
         if (j <= 16) begin
            total++;
            if (top_pc38 !== 38'(18 - j)) begin
               bad++;
               $display("FAIL ovf_ret%0d: got %h want %h", j, top_pc38, 38'(18 - j));
            end
         end
         drive(1'b0, 1'b1, 38'h0);
         if (j < 16)
            expect_q($sformatf("ovf_pop%0d", j), 38'(17 - j), 1'b1,
                     4'((17 - j) % 16), 5'(16 - j));
         else if (j == 16)
            expect_q("ovf_pop16", 38'd17, 1'b0, 4'd1, 5'd0);
         else
            expect_q("ovf_pop_empty", 38'd16, 1'b0, 4'd0, 5'd0);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
             {e.top, e.tv, e.ptr, e.cnt}) begin
            bad++;
            $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                     e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                     e.top, e.tv, e.ptr, e.cnt);
         end
      end
   endtask

   task automatic test_same_cycle();
      exp_t e;
      logic        pu [6];
      logic        po [6];
      logic [37:0] d  [6];
      pu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      po = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      d  = '{38'h100, 38'h200, 38'h300, 38'h400, 38'h0, 38'h555};
      do_reset();
      expect_q("sc_push1", 38'h100, 1'b1, 4'd1, 5'd1);
      expect_q("sc_push2", 38'h200, 1'b1, 4'd2, 5'd2);
      expect_q("sc_push3", 38'h300, 1'b1, 4'd3, 5'd3);
      expect_q("sc_pushpop", 38'h400, 1'b1, 4'd3, 5'd3);
      expect_q("sc_pop_after", 38'h200, 1'b1, 4'd2, 5'd2);
      expect_q("sc_pushpop2", 38'h555, 1'b1, 4'd2, 5'd2);
      for (int i = 0; i < 6; i++) begin
         drive(pu[i], po[i], d[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
             {e.top, e.tv, e.ptr, e.cnt}) begin
            bad++;
            $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                     e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                     e.top, e.tv, e.ptr, e.cnt);
         end
      end
      do_reset();
      drive(1'b1, 1'b1, 38'h777);
      expect_q("sc_empty_pushpop", 38'h777, 1'b1, 4'd0, 5'd1);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
          {e.top, e.tv, e.ptr, e.cnt}) begin
         bad++;
         $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                  e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                  e.top, e.tv, e.ptr, e.cnt);
      end
   endtask

   task automatic test_restore();
      exp_t e;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         unique case (i)
            0: begin
               drive(1'b1, 1'b0, 38'h11);
               expect_q("rs_push11", 38'h11, 1'b1, 4'd1, 5'd1);
            end
            1: begin
               drive(1'b1, 1'b0, 38'h22);
               expect_q("rs_push22", 38'h22, 1'b1, 4'd2, 5'd2);
            end
            2: begin
               drive(1'b1, 1'b0, 38'hAA);
               expect_q("rs_pushAA", 38'hAA, 1'b1, 4'd3, 5'd3);
            end
            3: begin
               drive(1'b1, 1'b0, 38'hBB);
               expect_q("rs_pushBB", 38'hBB, 1'b1, 4'd4, 5'd4);
            end
            4: begin
               drive(1'b1, 1'b0, 38'hCC);
               restore_valid = 1'b1;
               restore_ptr   = 4'd2;
               restore_count = 5'd2;
               expect_q("rs_restore", 38'h22, 1'b1, 4'd2, 5'd2);
            end
            5: begin
               drive(1'b0, 1'b1, 38'h0);
               restore_valid = 1'b1;
               restore_ptr   = 4'd5;
               restore_count = 5'd31;
               expect_q("rs_clamp", 38'h0, 1'b1, 4'd5, 5'd16);
            end
            default: begin
               restore_valid = 1'b1;
               restore_ptr   = 4'd2;
               restore_count = 5'd2;
`ifdef RAS_CKPT_TOP_REPAIR_EN
               restore_top_valid = 1'b1;
               restore_top_pc38  = 38'h123;
               expect_q("rs_repair", 38'h123, 1'b1, 4'd2, 5'd2);
`else
               expect_q("rs_norepair", 38'h22, 1'b1, 4'd2, 5'd2);
`endif
            end
         endcase
         tick();
         e = exp_q.pop_front();
         total++;
         if ({top_pc38, top_valid, ckpt_ptr, ckpt_count} !==
             {e.top, e.tv, e.ptr, e.cnt}) begin
            bad++;
            $display("FAIL %s: got top=%h v=%b ptr=%0d cnt=%0d want top=%h v=%b ptr=%0d cnt=%0d",
                     e.tag, top_pc38, top_valid, ckpt_ptr, ckpt_count,
                     e.top, e.tv, e.ptr, e.cnt);
         end
      end
   endtask

   initial begin
      RST           = 1'b0;
      push_valid    = 1'b0;
      push_pc38     = '0;
      pop_valid     = 1'b0;
      restore_valid = 1'b0;
      restore_ptr   = '0;
      restore_count = '0;
`ifdef RAS_CKPT_TOP_REPAIR_EN
      restore_top_valid = 1'b0;
      restore_top_pc38  = '0;
`endif
      #2;
      test_reset();
      test_push_pop();
      test_overflow();
      test_same_cycle();
      test_restore();
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard: got %0d leftover want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
